// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and constants for the boot program loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // States in which the host owes us a byte and the idle watchdog runs.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// rtl/prog_loader_timeout.sv - idle-cycle watchdog for bytes inside a frame
module prog_loader_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] count;

  // Saturates at the limit so expired stays asserted until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader into instruction memory
// Holds the core in reset until a frame with a valid checksum has been written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              load_error
);

  state_t      state, state_d;
  logic [7:0]  sum;
  logic [8:0]  cnt;
  logic        xfer;
  logic        expired;
  logic        is_sync;
  logic [7:0]  csum_chk;

  assign xfer     = rx_valid & rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign csum_chk = sum + rx_data;

  prog_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (in_frame(state) && !xfer),
    .clear   (xfer || !in_frame(state)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (xfer && is_sync) state_d = ST_LEN;
      ST_LEN:   if (expired) state_d = ST_ERR;
                else if (xfer) state_d = ST_DATA;
      ST_DATA:  if (expired) state_d = ST_ERR;
                else if (xfer) state_d = ST_WRITE;
      ST_WRITE: state_d = (cnt == 9'd1) ? ST_CSUM : ST_DATA;
      ST_CSUM:  if (expired) state_d = ST_ERR;
                else if (xfer) state_d = (csum_chk == 8'd0) ? ST_DONE : ST_ERR;
      ST_DONE,
      ST_ERR:   if (xfer && is_sync) state_d = ST_LEN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A LEN byte of zero encodes a full 256-byte payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= 9'd0;
      sum        <= 8'd0;
      imem_addr  <= '0;
      imem_wdata <= 8'd0;
    end else begin
      case (state)
        ST_LEN: if (xfer && !expired) begin
          cnt       <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          sum       <= 8'd0;
          imem_addr <= '0;
        end
        ST_DATA: if (xfer && !expired) begin
          imem_wdata <= rx_data;
          sum        <= sum + rx_data;
        end
        ST_WRITE: begin
          imem_addr <= imem_addr + ADDR_W'(1);
          cnt       <= cnt - 9'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      rx_ready     <= (state_d != ST_WRITE);
      imem_we      <= (state_d == ST_WRITE);
      core_reset_n <= (state_d == ST_DONE);
      load_done    <= (state_d == ST_DONE);
      load_error   <= (state_d == ST_ERR);
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader framing, checksum, timeout and reset
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_ready, imem_we, core_reset_n, load_done, load_error;
  logic [7:0] imem_addr, imem_wdata;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  payload[$];
  logic        prev_we = 1'b0;
  logic        bp_mode = 1'b0;

  prog_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset_n(core_reset_n), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", imem_addr, imem_wdata);
        end else begin
          check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
        end
        check("rx_ready_in_write", rx_ready, 1'b0);
        check("we_single_cycle", prev_we, 1'b0);
      end else if (bp_mode) begin
        check("rx_ready_outside_write", rx_ready, 1'b1);
      end
      prev_we = imem_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int  t;
    logic ok;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    forever begin
      ok = rx_ready;
      tick(1);
      if (ok) break;
      t++;
      if (t > 50) begin
        check("rx_ready_wait", 32'd0, 32'd1);
        break;
      end
    end
    if (gap > 0) begin
      rx_valid = 1'b0;
      tick(gap);
    end
  endtask

  task automatic run_body(input logic [7:0] csum, input int gap);
    send(8'(payload.size()), gap);
    for (int i = 0; i < payload.size(); i++) begin
      exp_q.push_back({8'(i), payload[i]});
      send(payload[i], gap);
    end
    send(csum, 0);
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] csum, input int gap);
    send(DEFAULT_SYNC_BYTE, gap);
    run_body(csum, gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_imem_we"}, imem_we, 1'b0);
    check({tag, "_imem_addr"}, imem_addr, 8'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 8'd0);
    check({tag, "_core_reset_n"}, core_reset_n, 1'b0);
    check({tag, "_load_done"}, load_done, 1'b0);
    check({tag, "_load_error"}, load_error, 1'b0);
  endtask

  initial begin
    int waited;

    // 1: reset values, then rx_ready comes up after release
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    tick(2);
    check("ready_after_release", rx_ready, 1'b1);

    // Non-sync byte in IDLE is discarded
    send(8'h33, 1);
    check("idle_discard_done", load_done, 1'b0);

    // 2: good frame 41,82,C3; sum 0x86 so checksum 0x7A
    payload = '{8'h41, 8'h82, 8'hC3};
    run_frame(8'h7A, 1);
    check("t2_core_reset_n", core_reset_n, 1'b1);
    check("t2_load_done", load_done, 1'b1);
    check("t2_load_error", load_error, 1'b0);
    check("t2_drained", exp_q.size(), 0);
    tick(2);

    // 3: bad checksum, then recovery frame 20,E0 with checksum 0
    run_frame(8'h7B, 1);
    check("t3_core_reset_n", core_reset_n, 1'b0);
    check("t3_load_error", load_error, 1'b1);
    check("t3_load_done", load_done, 1'b0);
    check("t3_drained", exp_q.size(), 0);
    tick(2);
    payload = '{8'h20};
    run_frame(8'hE0, 1);
    check("t3b_load_error", load_error, 1'b0);
    check("t3b_load_done", load_done, 1'b1);
    check("t3b_core_reset_n", core_reset_n, 1'b1);
    check("t3b_drained", exp_q.size(), 0);

    // DONE ignores non-sync bytes
    send(8'h5A, 1);
    check("done_ignore", load_done, 1'b1);

    // 5: back-to-back bytes with rx_valid held; reload from DONE
    bp_mode = 1'b1;
    send(DEFAULT_SYNC_BYTE, 0);
    check("reload_core_reset_n", core_reset_n, 1'b0);
    check("reload_load_done", load_done, 1'b0);
    payload = '{8'h10, 8'h20, 8'h30};
    run_body(8'hA0, 0);
    bp_mode = 1'b0;
    check("t5_load_done", load_done, 1'b1);
    check("t5_drained", exp_q.size(), 0);
    tick(2);

    // 4: timeout after one of two data bytes
    send(DEFAULT_SYNC_BYTE, 0);
    send(8'h02, 0);
    exp_q.push_back({8'h00, 8'h11});
    send(8'h11, 0);
    rx_valid = 1'b0;
    tick(10);
    check("t4_no_early_error", load_error, 1'b0);
    waited = 0;
    while (!load_error && waited < 5) begin
      tick(1);
      waited++;
    end
    check("t4_load_error", load_error, 1'b1);
    check("t4_core_reset_n", core_reset_n, 1'b0);
    check("t4_drained", exp_q.size(), 0);
    tick(2);

    // 6: LEN=0 means 256 bytes; 0x00..0xFF sums to 0x80, checksum 0x80
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    run_frame(8'h80, 0);
    check("t6_load_done", load_done, 1'b1);
    check("t6_load_error", load_error, 1'b0);
    check("t6_drained", exp_q.size(), 0);
    tick(2);

    // 6b: asynchronous reset in the middle of a 256-byte payload
    send(DEFAULT_SYNC_BYTE, 0);
    send(8'h00, 0);
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back({8'(i), 8'(i)});
      send(8'(i), 0);
    end
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    rx_valid = 1'b0;
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    tick(3);
    check("post_reset_ready", rx_ready, 1'b1);
    check("post_reset_done", load_done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
